alu_muldiv: RTL and testbench

Parametrised multi-cycle multiply/divide unit that extends the single-cycle ALU with the RISC-V M-extension operations. It sits beside the ALU in the execute stage. It accepts one operation per start pulse and iterates one bit per clock. Its result and flags are registered and held until the next operation completes, so the datapath can stall on `Busy` and capture `Result` on `Done`.

---
 rtl/alu_muldiv_pkg.sv | 37 +++
 rtl/alu_muldiv_if.sv | 32 +++
 rtl/alu_muldiv_step.sv | 34 +++
 rtl/alu_muldiv.sv | 146 ++++++++++++++
 tb/tb_alu_muldiv.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_muldiv_pkg.sv
// Shared opcodes, FSM encoding and operand-signedness helpers for the
// multi-cycle multiply/divide unit.
package alu_muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic is_signed_a(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/alu_muldiv_if.sv
// Request/response bundle between the execute stage and alu_muldiv.
interface alu_muldiv_if #(parameter int WIDTH = 32);
  import alu_muldiv_pkg::*;

  // Handshake: Start is sampled only while Busy=0; the operands and control
  // are captured on that edge and may change afterwards. Busy stays high until
  // the edge that raises Done, Done is a one-cycle pulse, and Result plus the
  // flags hold until the next Done. Start during Busy is dropped, not queued.
  logic             Start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       MulDivControl;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Result;
  logic             Zero;
  logic             Negative;
  logic             OverFlow;
  logic             DivByZero;
  state_t           dbg_state;

  modport master (
    output Start, A, B, MulDivControl,
    input  Busy, Done, Result, Zero, Negative, OverFlow, DivByZero, dbg_state
  );

  modport slave (
    input  Start, A, B, MulDivControl,
    output Busy, Done, Result, Zero, Negative, OverFlow, DivByZero, dbg_state
  );

endinterface

// File: rtl/alu_muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply step or
// restoring-division step, chosen by is_div.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] hi_n,
  output logic [WIDTH-1:0] lo_n
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   r_shift;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    // r_shift carries the guard bit so the trial compare never wraps
    r_shift = {hi, lo[WIDTH-1]};
    ge      = r_shift >= {1'b0, opnd};
    diff    = r_shift[WIDTH-1:0] - opnd;
    if (is_div) begin
      hi_n = ge ? diff : r_shift[WIDTH-1:0];
      lo_n = {lo[WIDTH-2:0], ge};
    end else begin
      hi_n = sum[WIDTH:1];
      lo_n = {sum[0], lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Multi-cycle RISC-V M-extension unit: magnitude iteration one bit per clock,
// sign fix-up and registered result/flags on completion.
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         rst,
  alu_muldiv_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state, state_n;

  logic [CW-1:0]    cnt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
  logic             sign_q, ovf_q, dbz_q;

  logic [2:0]       op_in;
  logic             a_neg, b_neg, fast_dbz, fast_ovf, start_sign;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0] quo_s, rem_s, res_n;

  always_comb begin
    op_in      = bus.MulDivControl;
    a_neg      = is_signed_a(op_in) & bus.A[WIDTH-1];
    b_neg      = is_signed_b(op_in) & bus.B[WIDTH-1];
    mag_a      = a_neg ? -bus.A : bus.A;
    mag_b      = b_neg ? -bus.B : bus.B;
    fast_dbz   = is_div(op_in) && (bus.B == '0);
    fast_ovf   = is_div(op_in) && !op_in[0] && (bus.A == MIN_NEG) && (bus.B == '1);
    // Fast-path results are already final, so they must not be negated
    if (fast_dbz || fast_ovf) start_sign = 1'b0;
    else if (is_rem(op_in))   start_sign = a_neg;
    else                      start_sign = a_neg ^ b_neg;
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (is_div(op_q)),
    .hi     (hi_q),
    .lo     (lo_q),
    .opnd   (opnd_q),
    .hi_n   (hi_n),
    .lo_n   (lo_n)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n       = state;
    bus.Busy      = (state != S_IDLE);
    bus.dbg_state = state;
    case (state)
      S_IDLE: if (bus.Start) state_n = (fast_dbz || fast_ovf) ? S_DONE : S_CALC;
      S_CALC: if (cnt == CW'(1)) state_n = S_DONE;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      op_q   <= OP_MUL;
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      sign_q <= 1'b0;
      ovf_q  <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.Start) begin
            op_q   <= op_in;
            cnt    <= CW'(WIDTH);
            sign_q <= start_sign;
            ovf_q  <= fast_ovf;
            dbz_q  <= fast_dbz;
            opnd_q <= is_div(op_in) ? mag_b : mag_a;
            // hi holds the high product / remainder, lo the multiplier / quotient
            if (fast_dbz) begin
              hi_q <= bus.A;
              lo_q <= '1;
            end else if (fast_ovf) begin
              hi_q <= '0;
              lo_q <= bus.A;
            end else begin
              hi_q <= '0;
              lo_q <= is_div(op_in) ? mag_a : mag_b;
            end
          end
        end
        S_CALC: begin
          hi_q <= hi_n;
          lo_q <= lo_n;
          cnt  <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    prod_s = sign_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    quo_s  = sign_q ? -lo_q : lo_q;
    rem_s  = sign_q ? -hi_q : hi_q;
    case (op_q)
      OP_MUL:                       res_n = prod_s[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res_n = prod_s[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              res_n = quo_s;
      OP_REM, OP_REMU:              res_n = rem_s;
      default:                      res_n = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.Done      <= 1'b0;
      bus.Result    <= '0;
      bus.Zero      <= 1'b0;
      bus.Negative  <= 1'b0;
      bus.OverFlow  <= 1'b0;
      bus.DivByZero <= 1'b0;
    end else begin
      bus.Done <= (state == S_DONE);
      if (state == S_DONE) begin
        bus.Result    <= res_n;
        bus.Zero      <= (res_n == '0);
        bus.Negative  <= res_n[WIDTH-1];
        bus.OverFlow  <= ovf_q;
        bus.DivByZero <= dbz_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed-vector bench for alu_muldiv at WIDTH=32 with hand-computed results.
module tb_alu_muldiv;
  import alu_muldiv_pkg::*;

  localparam int W   = 32;
  localparam int LAT = W + 1;  // negedges after the start edge until Done is seen

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;

  alu_muldiv_if #(.WIDTH(W)) bus ();

  alu_muldiv #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge following the start edge.
  task automatic start_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.Start         = 1'b1;
    bus.MulDivControl = op;
    bus.A             = a;
    bus.B             = b;
    @(posedge clk);
    @(negedge clk);
    bus.Start         = 1'b0;
    bus.A             = $urandom();
    bus.B             = $urandom();
    bus.MulDivControl = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (bus.Done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    if ({bus.Busy, bus.Done, bus.Zero, bus.Negative, bus.OverFlow, bus.DivByZero} !== 6'b0) begin
      mismatched++;
      $display("FAIL reset_flags: got %b expected 000000",
               {bus.Busy, bus.Done, bus.Zero, bus.Negative, bus.OverFlow, bus.DivByZero});
    end
    compared++;
    if (bus.Result !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_result: got %h expected 00000000", bus.Result);
    end
    compared++;
    if (bus.dbg_state !== S_IDLE) begin
      mismatched++;
      $display("FAIL reset_state: got %0d expected %0d", bus.dbg_state, S_IDLE);
    end
    compared++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul_basic();
    int busy_cnt = 0;
    int done_at  = -1;
    bus.Start = 1'b1; bus.MulDivControl = OP_MUL; bus.A = 32'd5; bus.B = 32'd3;
    @(posedge clk);
    for (int j = 0; j < 60; j++) begin
      @(negedge clk);
      if (bus.Busy === 1'b1) busy_cnt++;
      if (bus.Done === 1'b1) begin
        done_at = j;
        break;
      end
      // the pulse driven at j==9 lands on the edge of cycle 10, mid-operation
      bus.Start = (j == 9);
      bus.A     = 32'd100;
      bus.B     = 32'd100;
    end
    bus.Start = 1'b0;
    if (done_at !== LAT) begin
      mismatched++;
      $display("FAIL mul_latency: got %0d expected %0d", done_at, LAT);
    end
    compared++;
    if (busy_cnt !== LAT) begin
      mismatched++;
      $display("FAIL mul_busy_cycles: got %0d expected %0d", busy_cnt, LAT);
    end
    compared++;
    if (bus.Result !== 32'd15 || bus.Zero !== 1'b0) begin
      mismatched++;
      $display("FAIL mul_5x3: got %h zero %b expected 0000000f zero 0", bus.Result, bus.Zero);
    end
    compared++;
    @(negedge clk);
    if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
      mismatched++;
      $display("FAIL mul_ignored_start: got done %b busy %b expected 0 0", bus.Done, bus.Busy);
    end
    compared++;
  endtask

  task automatic test_mul_high();
    logic [2:0]   ops [4] = '{OP_MULH, OP_MULHU, OP_MULHSU, OP_MUL};
    logic [W-1:0] av  [4] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFD};
    logic [W-1:0] bv  [4] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000005};
    logic [W-1:0] rv  [4] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF1};
    logic         nv  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    int lat;
    for (int i = 0; i < 4; i++) begin
      start_op(ops[i], av[i], bv[i]);
      wait_done(lat);
      if (lat !== LAT || bus.Result !== rv[i] || bus.Negative !== nv[i]) begin
        mismatched++;
        $display("FAIL mul_vec%0d: got %h neg %b lat %0d expected %h neg %b lat %0d",
                 i, bus.Result, bus.Negative, lat, rv[i], nv[i], LAT);
      end
      compared++;
      if (bus.OverFlow !== 1'b0 || bus.DivByZero !== 1'b0) begin
        mismatched++;
        $display("FAIL mul_flags%0d: got ovf %b dbz %b expected 0 0", i, bus.OverFlow, bus.DivByZero);
      end
      compared++;
      @(negedge clk);
    end
  endtask

  task automatic test_div();
    logic [2:0]   ops [6] = '{OP_DIV, OP_REM, OP_DIVU, OP_REM, OP_DIVU, OP_REMU};
    logic [W-1:0] av  [6] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'd6, 32'hFFFFFFFF, 32'd100};
    logic [W-1:0] bv  [6] = '{32'd2, 32'd2, 32'd7, 32'd3, 32'h10, 32'd7};
    logic [W-1:0] rv  [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd1, 32'd0, 32'h0FFFFFFF, 32'd2};
    logic         zv  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int lat;
    for (int i = 0; i < 6; i++) begin
      start_op(ops[i], av[i], bv[i]);
      wait_done(lat);
      if (lat !== LAT || bus.Result !== rv[i] || bus.Zero !== zv[i]) begin
        mismatched++;
        $display("FAIL div_vec%0d: got %h zero %b lat %0d expected %h zero %b lat %0d",
                 i, bus.Result, bus.Zero, lat, rv[i], zv[i], LAT);
      end
      compared++;
      if (bus.OverFlow !== 1'b0 || bus.DivByZero !== 1'b0) begin
        mismatched++;
        $display("FAIL div_flags%0d: got ovf %b dbz %b expected 0 0", i, bus.OverFlow, bus.DivByZero);
      end
      compared++;
      @(negedge clk);
    end
  endtask

  task automatic test_fast_paths();
    logic [2:0]   ops [6] = '{OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_DIV, OP_REM};
    logic [W-1:0] av  [6] = '{32'd9, 32'd9, 32'h80000000, 32'h80000000, 32'hFFFFFFF9, 32'hFFFFFFF9};
    logic [W-1:0] bv  [6] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
    logic [W-1:0] rv  [6] = '{32'hFFFFFFFF, 32'd9, 32'h80000000, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF9};
    logic         ov  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic         dv  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int lat;
    for (int i = 0; i < 6; i++) begin
      start_op(ops[i], av[i], bv[i]);
      wait_done(lat);
      if (lat !== 1 || bus.Result !== rv[i]) begin
        mismatched++;
        $display("FAIL fast_vec%0d: got %h lat %0d expected %h lat 1", i, bus.Result, lat, rv[i]);
      end
      compared++;
      if (bus.OverFlow !== ov[i] || bus.DivByZero !== dv[i]) begin
        mismatched++;
        $display("FAIL fast_flags%0d: got ovf %b dbz %b expected ovf %b dbz %b",
                 i, bus.OverFlow, bus.DivByZero, ov[i], dv[i]);
      end
      compared++;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int   lat;
    logic held_ok = 1'b1;
    logic busy0;
    start_op(OP_MUL, 32'd6, 32'd7);
    wait_done(lat);
    if (bus.Result !== 32'd42) begin
      mismatched++;
      $display("FAIL b2b_first: got %h expected 0000002a", bus.Result);
    end
    compared++;
    // still in the Done cycle: this start must be accepted
    start_op(OP_DIVU, 32'd100, 32'd7);
    busy0 = bus.Busy;
    lat = 0;
    while (bus.Done !== 1'b1 && lat < 200) begin
      if (bus.Result !== 32'd42) held_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (busy0 !== 1'b1 || lat !== LAT) begin
      mismatched++;
      $display("FAIL b2b_accept: got busy %b lat %0d expected busy 1 lat %0d", busy0, lat, LAT);
    end
    compared++;
    if (held_ok !== 1'b1) begin
      mismatched++;
      $display("FAIL b2b_hold: got held %b expected 1", held_ok);
    end
    compared++;
    if (bus.Result !== 32'd14) begin
      mismatched++;
      $display("FAIL b2b_second: got %h expected 0000000e", bus.Result);
    end
    compared++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    int done_seen = 0;
    int lat;
    start_op(OP_DIV, 32'd100, 32'd3);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    if ({bus.Busy, bus.Done, bus.Zero, bus.Negative, bus.OverFlow, bus.DivByZero} !== 6'b0 ||
        bus.Result !== 32'h0) begin
      mismatched++;
      $display("FAIL midreset_outputs: got flags %b result %h expected 000000 00000000",
               {bus.Busy, bus.Done, bus.Zero, bus.Negative, bus.OverFlow, bus.DivByZero}, bus.Result);
    end
    compared++;
    if (bus.dbg_state !== S_IDLE) begin
      mismatched++;
      $display("FAIL midreset_state: got %0d expected %0d", bus.dbg_state, S_IDLE);
    end
    compared++;
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.Done === 1'b1) done_seen++;
    end
    if (done_seen !== 0) begin
      mismatched++;
      $display("FAIL midreset_no_done: got %0d pulses expected 0", done_seen);
    end
    compared++;
    start_op(OP_MUL, 32'd2, 32'd2);
    wait_done(lat);
    if (lat !== LAT || bus.Result !== 32'd4) begin
      mismatched++;
      $display("FAIL midreset_recover: got %h lat %0d expected 00000004 lat %0d", bus.Result, lat, LAT);
    end
    compared++;
    @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.Start         = 1'b0;
    bus.A             = '0;
    bus.B             = '0;
    bus.MulDivControl = OP_MUL;
    @(negedge clk);
    test_reset();
    test_mul_basic();
    test_mul_high();
    test_div();
    test_fast_paths();
    test_back_to_back();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
